pwm_dac_strobe_gen: RTL and testbench

PWM DAC driver for the SAR ADC loop. It takes the 8-bit trial value from the SAR controller and produces a PWM waveform whose RC-filtered average is the DAC voltage. Once the filter has settled it emits a one-clock `strobe`, which drives the SAR controller's `en` input and advances the binary search one step. It sits between the SAR controller's `value`/`en` pins and the FPGA pin that feeds the RC filter and comparator.

---
 rtl/sar_pwm_pkg.sv | 7 +
 rtl/pwm_tick_prescaler.sv | 42 ++++
 rtl/pwm_dac_strobe_gen.sv | 96 +++++++++
 tb/tb_pwm_dac_strobe_gen.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pwm_pkg.sv
// Shared constants for the SAR-loop PWM DAC blocks.
package sar_pwm_pkg;

    localparam int DATA_W = 8;
    localparam logic [DATA_W-1:0] PWM_MAX = 8'hFF;

endpackage : sar_pwm_pkg

// File: rtl/pwm_tick_prescaler.sv
// Clock prescaler for PWM blocks: emits a one-clock tick every PRESCALE
// clocks while clr is low; clr holds the count at zero.
module pwm_tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("pwm_tick_prescaler: PRESCALE must be >= 1");
    end

    logic [PRE_W-1:0] pre_q, pre_d;

    // Next prescaler count: wrap at PRESCALE-1, clear while idle.
    always_comb begin
        pre_d = pre_q;
        if (clr || pre_q == PRE_LAST) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    assign tick = !clr && (pre_q == PRE_LAST);

    // Prescaler count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule : pwm_tick_prescaler

// File: rtl/pwm_dac_strobe_gen.sv
// PWM DAC driver for the SAR ADC loop: shadowed 8-bit duty, registered PWM
// output, and a settle strobe every SETTLE_PERIODS+1 PWM periods.
module pwm_dac_strobe_gen
    import sar_pwm_pkg::*;
#(
    parameter int PRESCALE       = 1,
    parameter int SETTLE_PERIODS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] value,
    output logic              pwm,
    output logic              strobe,
    output logic [DATA_W-1:0] duty
);

    localparam int SCNT_W = $clog2(SETTLE_PERIODS + 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SETTLE_PERIODS);

    if (SETTLE_PERIODS < 1) begin : g_bad_settle
        $error("pwm_dac_strobe_gen: SETTLE_PERIODS must be >= 1");
    end

    logic              tick;
    logic              boundary;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] duty_q, duty_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic              pwm_q, pwm_d;
    logic              strobe_q, strobe_d;

    pwm_tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clr  (!run),
        .tick (tick)
    );

    // Last count of the period on a tick: shadow load and settle step.
    assign boundary = tick && (cnt_q == PWM_MAX);

    // Period counter, shadow duty, compare and settle/strobe next state.
    // The run=0 branch takes priority so a boundary coinciding with run
    // falling neither strobes nor advances the settle count.
    always_comb begin
        cnt_d    = cnt_q;
        duty_d   = duty_q;
        scnt_d   = scnt_q;
        pwm_d    = 1'b0;
        strobe_d = 1'b0;
        if (!run) begin
            cnt_d  = '0;
            scnt_d = '0;
            duty_d = value;
        end else begin
            pwm_d = (cnt_q < duty_q);
            if (tick) begin
                cnt_d = cnt_q + DATA_W'(1);
            end
            if (boundary) begin
                duty_d = value;
                if (scnt_q == SCNT_LAST) begin
                    scnt_d   = '0;
                    strobe_d = 1'b1;
                end else begin
                    scnt_d = scnt_q + SCNT_W'(1);
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            duty_q   <= '0;
            scnt_q   <= '0;
            pwm_q    <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            duty_q   <= duty_d;
            scnt_q   <= scnt_d;
            pwm_q    <= pwm_d;
            strobe_q <= strobe_d;
        end
    end

    assign pwm    = pwm_q;
    assign strobe = strobe_q;
    assign duty   = duty_q;

endmodule : pwm_dac_strobe_gen

// File: tb/tb_pwm_dac_strobe_gen.sv
// Bench for pwm_dac_strobe_gen: a PRESCALE=1/SETTLE=1 instance (A) and a
// PRESCALE=3/SETTLE=2 instance (B) sharing clock and reset.
module tb_pwm_dac_strobe_gen;

    logic       clk;
    logic       rst;
    logic       run_a, run_b;
    logic [7:0] value_a, value_b;
    logic       pwm_a, pwm_b;
    logic       strobe_a, strobe_b;
    logic [7:0] duty_a, duty_b;

    int checks = 0;
    int errors = 0;

    pwm_dac_strobe_gen #(
        .PRESCALE      (1),
        .SETTLE_PERIODS(1)
    ) dut_a (
        .clk   (clk),
        .reset (rst),
        .run   (run_a),
        .value (value_a),
        .pwm   (pwm_a),
        .strobe(strobe_a),
        .duty  (duty_a)
    );

    pwm_dac_strobe_gen #(
        .PRESCALE      (3),
        .SETTLE_PERIODS(2)
    ) dut_b (
        .clk   (clk),
        .reset (rst),
        .run   (run_b),
        .value (value_b),
        .pwm   (pwm_b),
        .strobe(strobe_b),
        .duty  (duty_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [7:0] value;
        int         chg_at;
        int         exp_high;
    } vec_t;

    typedef struct {
        int         hi;
        int         st;
        logic [7:0] dmid;
        logic [7:0] dend;
    } exp_t;

    vec_t       vecs[7];
    exp_t       sb[$];
    logic [7:0] sar_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One 256-clock period of instance A, starting at a negedge aligned to cnt=0.
    task automatic win_a(input logic [7:0] nxt, input int chg_at, output int hi,
                         output int first_low, output int st, output int st_pos,
                         output logic [7:0] duty_mid);
        hi = 0; first_low = -1; st = 0; st_pos = -1; duty_mid = '0;
        for (int i = 0; i < 256; i++) begin
            if (i == chg_at) value_a = nxt;
            cyc();
            if (pwm_a) hi++;
            else if (first_low < 0) first_low = i;
            if (strobe_a) begin
                st++;
                st_pos = i;
            end
            if (i == 200) duty_mid = duty_a;
        end
    endtask

    // Cycles until the selected strobe is seen; -1 when the budget expires.
    task automatic wait_strobe(input bit sel_b, input int budget, output int n);
        n = 0;
        while (1) begin
            cyc();
            n++;
            if (sel_b ? strobe_b : strobe_a) return;
            if (n >= budget) begin
                n = -1;
                return;
            end
        end
    endtask

    initial begin
        int         hi, fl, st, sp, n, nstb;
        logic [7:0] dm, nxt, trial, mask;
        logic       valid;
        exp_t       e;

        vecs[0] = '{8'h40, 0,   64};
        vecs[1] = '{8'h00, 10,  0};
        vecs[2] = '{8'hFF, 10,  255};
        vecs[3] = '{8'h10, 10,  16};
        vecs[4] = '{8'hC0, 100, 192};
        vecs[5] = '{8'h01, 10,  1};
        vecs[6] = '{8'h80, 10,  128};

        rst = 1'b1; run_a = 1'b0; run_b = 1'b0;
        value_a = 8'h40; value_b = 8'h05;
        repeat (3) cyc();
        chk("reset_pwm_a", pwm_a, 0);
        chk("reset_strobe_a", strobe_a, 0);
        chk("reset_duty_a", duty_a, 0);
        chk("reset_pwm_b", pwm_b, 0);
        chk("reset_duty_b", duty_b, 0);
        rst = 1'b0;
        cyc();
        chk("idle_duty_track", duty_a, 8'h40);
        chk("idle_pwm", pwm_a, 0);

        // Table-driven periods with value changes ahead of each boundary.
        run_a = 1'b1;
        for (int j = 0; j < 7; j++) begin
            nxt = (j < 6) ? vecs[j+1].value : vecs[j].value;
            sb.push_back('{vecs[j].exp_high, (j % 2 == 1) ? 1 : 0, vecs[j].value, nxt});
            win_a(nxt, (j < 6) ? vecs[j+1].chg_at : 10, hi, fl, st, sp, dm);
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("high_time[%0d]", j), hi, e.hi);
                chk($sformatf("first_low[%0d]", j), fl, e.hi);
                chk($sformatf("strobe_count[%0d]", j), st, e.st);
                if (e.st == 1) chk($sformatf("strobe_pos[%0d]", j), sp, 255);
                chk($sformatf("duty_mid[%0d]", j), dm, e.dmid);
                chk($sformatf("duty_end[%0d]", j), duty_a, e.dend);
            end
        end

        // run falls at cnt=50 while pwm would be high.
        repeat (50) cyc();
        run_a = 1'b0;
        value_a = 8'h33;
        cyc();
        chk("runfall_pwm", pwm_a, 0);
        chk("runfall_strobe", strobe_a, 0);
        chk("runfall_duty", duty_a, 8'h33);
        st = 0;
        for (int i = 0; i < 600; i++) begin
            cyc();
            if (strobe_a) st++;
        end
        chk("idle_no_strobe", st, 0);

        // Re-enable: first strobe (1+1)*256*1 clocks later.
        value_a = 8'h80;
        run_a = 1'b1;
        wait_strobe(0, 2000, n);
        chk("reenable_latency", n, 512);

        // run falls exactly on the next strobing boundary edge.
        st = 0;
        for (int i = 0; i < 511; i++) begin
            cyc();
            if (strobe_a) st++;
        end
        chk("pre_boundary_no_strobe", st, 0);
        run_a = 1'b0;
        cyc();
        chk("boundary_runfall_strobe", strobe_a, 0);
        repeat (20) cyc();
        run_a = 1'b1;
        wait_strobe(0, 2000, n);
        chk("boundary_reenable_latency", n, 512);
        cyc();
        chk("strobe_width", strobe_a, 0);

        // Asynchronous reset mid-period.
        repeat (99) cyc();
        chk("pre_reset_pwm_high", pwm_a, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_reset_pwm", pwm_a, 0);
        chk("async_reset_duty", duty_a, 0);
        chk("async_reset_strobe", strobe_a, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_strobe(0, 2000, n);
        chk("post_reset_latency", n, 512);

        // Closed loop with a SAR controller model and ideal comparator.
        run_a = 1'b0;
        trial = 8'h80; mask = 8'h80; valid = 1'b0; nstb = 0;
        value_a = trial;
        foreach (vecs[k]) if (k < 0) sar_q.push_back(8'h00);
        sar_q.push_back(8'h80); sar_q.push_back(8'hC0); sar_q.push_back(8'hA0);
        sar_q.push_back(8'h90); sar_q.push_back(8'h98); sar_q.push_back(8'h9C);
        sar_q.push_back(8'h9A); sar_q.push_back(8'h9B);
        cyc();
        run_a = 1'b1;
        for (int c = 0; c < 6000 && !valid; c++) begin
            cyc();
            if (strobe_a) begin
                nstb++;
                if (mask != 0) begin
                    if (sar_q.size() == 0) chk("sar_queue_empty", 1, 0);
                    else chk($sformatf("sar_trial[%0d]", nstb), duty_a, sar_q.pop_front());
                    if (!(duty_a <= 8'h9A)) trial = trial & ~mask;
                    mask = mask >> 1;
                    trial = trial | mask;
                    value_a = trial;
                end else begin
                    valid = 1'b1;
                end
            end
        end
        chk("sar_valid", valid, 1);
        chk("sar_result", trial, 8'h9A);
        chk("sar_strobes", nstb, 9);
        run_a = 1'b0;

        // Instance B: 768-clock period, 2304-clock strobe interval.
        run_b = 1'b1;
        n = 0; hi = 0; fl = -1; st = 0;
        while (1) begin
            cyc();
            if (n < 768) begin
                if (pwm_b) hi++;
                else if (fl < 0) fl = n;
            end
            n++;
            if (strobe_b) break;
            if (n >= 3000) begin
                n = -1;
                break;
            end
        end
        chk("b_high_time", hi, 15);
        chk("b_first_low", fl, 15);
        chk("b_first_strobe", n, 2304);
        wait_strobe(1, 3000, n);
        chk("b_strobe_interval", n, 2304);
        cyc();
        chk("b_strobe_width", strobe_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pwm_dac_strobe_gen
